// File: rtl/rr_mux_select_sequencer.sv
// Round-robin sequencer driving a 4:1 single-bit mux select; holds select HOLD_CYCLES before sampling.
// Request to out_valid: 1 + HOLD_CYCLES edges; PRESENT holds all outputs until out_ready, then acks.
module rr_mux_select_sequencer #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic       s1,
  output logic       s2,
  input  logic       mux_out,
  output logic       out_data,
  output logic [1:0] out_chan,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] ack
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] PRESENT = 2'd2;

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] ptr;
  logic [1:0] sel;
  logic [7:0] hold_cnt;
  logic [1:0] grant;
  logic [1:0] idx;
  logic       found;

  assign s1 = sel[1];
  assign s2 = sel[0];

  // First requesting channel at or after ptr, wrapping mod 4.
  always_comb begin
    grant = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      sel       <= 2'd0;
      out_data  <= 1'b0;
      out_chan  <= 2'd0;
      out_valid <= 1'b0;
      ack       <= 4'd0;
      hold_cnt  <= 8'd0;
    end else begin
      ack <= 4'd0;
      case (state)
        IDLE: begin
          if (found) begin
            sel      <= grant;
            out_chan <= grant;
            hold_cnt <= HOLD_INIT;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (hold_cnt != 8'd0) begin
            hold_cnt <= hold_cnt - 8'd1;
          end else begin
            out_data  <= mux_out;
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          // Rotating ptr past the served channel keeps a persistent requester from starving others.
          if (out_ready) begin
            out_valid <= 1'b0;
            ack       <= 4'b0001 << out_chan;
            ptr       <= out_chan + 2'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_select_sequencer.sv
// Directed bench for rr_mux_select_sequencer: scoreboard of expected {chan,data} checked at each handshake.
module tb_rr_mux_select_sequencer;

  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       s1, s2;
  logic       mux_out;
  logic       out_data;
  logic [1:0] out_chan;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] ack;
  logic [3:0] mux_in;
  logic       tog_en, tog;

  int checks = 0;
  int passes = 0;
  int hs_count = 0;
  int cyc = 0;
  logic [2:0] exp_q[$];
  int hs_cyc[$];
  logic [3:0] pend_ack;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mux_out = tog_en ? tog : mux_in[{s1, s2}];

  rr_mux_select_sequencer #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .s1(s1), .s2(s2), .mux_out(mux_out),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready), .ack(ack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // req visible for exactly one sampling edge; returns 1 time unit after that edge.
  task automatic pulse_req(input logic [3:0] r);
    tick();
    req = r;
    tick();
    req = 4'd0;
  endtask

  task automatic do_reset(input int n);
    tick();
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int maxc);
    int n = 0;
    while (!out_valid && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      $display("FAIL wait_valid: out_valid never rose within %0d cycles", maxc);
    end
  endtask

  task automatic wait_hs(input int target, input int maxc);
    int n = 0;
    while (hs_count < target && n < maxc) begin
      tick();
      n++;
    end
    if (hs_count < target) begin
      checks++;
      $display("FAIL wait_hs: handshakes %0d required %0d", hs_count, target);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, then checks the ack pulse that follows.
  initial begin
    logic [2:0] e;
    pend_ack = 4'd0;
    forever begin
      @(negedge clk);
      if (pend_ack != 4'd0) begin
        check("ack_pulse", 32'(ack), 32'(pend_ack));
        pend_ack = 4'd0;
      end else if (ack != 4'd0) begin
        check("ack_spurious", 32'(ack), 32'd0);
      end
      if (rst_n && out_valid && out_ready) begin
        hs_count++;
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL sb_unexpected: chan %0d data %0d with empty scoreboard", out_chan, out_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_chan", 32'(out_chan), 32'(e[2:1]));
          check("sb_data", 32'(out_data), 32'(e[0]));
        end
        pend_ack = 4'b0001 << out_chan;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    rst_n = 1'b0; req = 4'hF; out_ready = 1'b0; mux_in = 4'd0; tog_en = 1'b0; tog = 1'b0;

    // T1 reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sel", 32'({s1, s2}), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_chan", 32'(out_chan), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    req = 4'd0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rel_sel", 32'({s1, s2}), 32'd0);
    check("rel_out_valid", 32'(out_valid), 32'd0);

    // T2 single transaction, latency
    mux_in = 4'b0100;
    exp_q.push_back({2'd2, 1'b1});
    pulse_req(4'b0100);
    @(negedge clk);
    check("t2_sel", 32'({s1, s2}), 32'd2);
    check("t2_valid_t1", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    check("t2_valid_t2", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    check("t2_valid_t3", 32'(out_valid), 32'd1);
    check("t2_data", 32'(out_data), 32'd1);
    check("t2_chan", 32'(out_chan), 32'd2);
    tick();
    out_ready = 1'b1;
    wait_hs(1, 10);
    repeat (2) tick();
    out_ready = 1'b0;

    // T3 fairness and throughput
    do_reset(2);
    mux_in = 4'b1010;
    base = hs_count;
    exp_q.push_back({2'd0, 1'b0});
    exp_q.push_back({2'd1, 1'b1});
    exp_q.push_back({2'd2, 1'b0});
    exp_q.push_back({2'd3, 1'b1});
    exp_q.push_back({2'd0, 1'b0});
    out_ready = 1'b1;
    req = 4'hF;
    n = 0;
    while (hs_count < base + 5 && n < 100) begin
      tick();
      n++;
    end
    req = 4'd0;
    if (hs_count < base + 5) begin
      checks++;
      $display("FAIL t3_count: handshakes %0d required %0d", hs_count - base, 5);
    end else begin
      for (int k = 1; k < 5; k++)
        check("t3_spacing", 32'(hs_cyc[base + k] - hs_cyc[base + k - 1]), 32'(HOLD + 2));
    end
    tick();
    out_ready = 1'b0;
    tick();

    // T4 backpressure with toggling mux_out
    mux_in = 4'b0010;
    base = hs_count;
    exp_q.push_back({2'd1, 1'b1});
    pulse_req(4'b0010);
    wait_valid(20);
    tog_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      tog = ~tog;
      @(negedge clk);
      check("t4_hold", 32'({out_valid, out_data, out_chan, s1, s2}), 32'(6'b1_1_01_01));
    end
    tog_en = 1'b0;
    tick();
    out_ready = 1'b1;
    wait_hs(base + 1, 20);
    tick();
    out_ready = 1'b0;

    // T5 wrap past 3 and skip idle channels
    mux_in = 4'b0110;
    base = hs_count;
    exp_q.push_back({2'd2, 1'b1});
    out_ready = 1'b1;
    pulse_req(4'b0100);
    wait_hs(base + 1, 20);
    exp_q.push_back({2'd0, 1'b0});
    exp_q.push_back({2'd1, 1'b1});
    req = 4'b0011;
    n = 0;
    while (hs_count < base + 3 && n < 50) begin
      tick();
      n++;
    end
    req = 4'd0;
    if (hs_count < base + 3) begin
      checks++;
      $display("FAIL t5_count: handshakes %0d required %0d", hs_count - base, 3);
    end
    tick();
    out_ready = 1'b0;
    tick();

    // T6 reset in SETTLE, then in PRESENT, then normal service
    mux_in = 4'b1000;
    base = hs_count;
    pulse_req(4'b1000);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("t6_settle_valid", 32'(out_valid), 32'd0);
    check("t6_settle_sel", 32'({s1, s2}), 32'd0);
    rst_n = 1'b1;
    tick();
    pulse_req(4'b1000);
    wait_valid(20);
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("t6_present_valid", 32'(out_valid), 32'd0);
    check("t6_present_chan", 32'(out_chan), 32'd0);
    check("t6_present_sel", 32'({s1, s2}), 32'd0);
    rst_n = 1'b1;
    exp_q.push_back({2'd3, 1'b1});
    out_ready = 1'b1;
    pulse_req(4'b1000);
    wait_hs(base + 1, 20);
    tick();
    out_ready = 1'b0;

    repeat (3) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
